alu_sequencer: RTL
==================

Name: alu_sequencer

Overview:
- Multi-cycle controller that owns the single shared 32-bit ALU and runs requests on it one at a time.
- Uses a valid/ready request port and a valid/ready response port.
- Builds the RV32I compare and shift results the ALU cannot produce directly (SLT, SLTU, EQ, SLL) from ALU primitives (ADD, SUB, AND, OR) and the ALU flags.
- Sits between decode/execute control and the ALU instance. The ALU itself stays outside this block.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU.
- SHAMT_W, 5, shift-amount width taken from req_b[SHAMT_W-1:0].

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 SLTU, 6 SLL, 7 EQ.
- req_a  in  WIDTH  operand A.
- req_b  in  WIDTH  operand B (shift amount for SLL).
- alu_a  out  WIDTH  to ALU a.
- alu_b  out  WIDTH  to ALU b.
- alu_control  out  4  to ALU control (0 ADD, 1 SUB, 2 AND, 3 OR).
- alu_out  in  WIDTH  from ALU out.
- alu_zero, alu_neg, alu_carry, alu_overflow  in  1 each  ALU flags.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  WIDTH  result.
- rsp_zero  out  1  rsp_data == 0.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, EXEC, SHIFT, RESP. Reset enters IDLE.
- Reset values: all registered outputs 0, i.e. rsp_valid=0, rsp_data=0, rsp_zero=0, busy=0, and alu_a/alu_b/alu_control=0. req_ready=1 in IDLE after reset.
- Reset asserted mid-operation: the in-flight request is discarded, no response is produced, and the next state is IDLE.
- req_ready=1 only in IDLE. Accept = req_valid && req_ready. On accept, latch op, A, B and shamt.
- Next state after accept: EXEC, or SHIFT when op=SLL.
- EXEC (exactly 1 cycle):
  - Drive alu_a=A and alu_b=B.
  - alu_control: op itself for ops 0-3; SUB for SLT, SLTU and EQ.
  - At the end of the cycle, capture the result:
    - ops 0-3: alu_out.
    - SLT: {31'b0, alu_neg ^ alu_overflow}.
    - SLTU: {31'b0, alu_carry}. The carry is a borrow, 1 when A<B unsigned.
    - EQ: {31'b0, alu_zero}.
  - Next state: RESP.
- SHIFT:
  - Accumulator acc is loaded with A on accept.
  - Each cycle: alu_a=acc, alu_b=acc, alu_control=ADD; acc <= alu_out; remaining count decrements.
  - With shamt=n>0, exactly n SHIFT cycles, then RESP with rsp_data=acc.
  - With shamt=0, one SHIFT cycle driving alu_b=0, so the result is A.
  - req_b[31:SHAMT_W] is ignored.
- RESP:
  - rsp_valid=1; rsp_data and rsp_zero are held stable while rsp_ready=0 (stall of any length).
  - On rsp_valid && rsp_ready the next state is IDLE and rsp_valid drops the next cycle.
  - A new request can be accepted no earlier than the cycle after the handshake, because req_ready is not asserted in RESP (no back-to-back overlap).
- Latency, counted from the accept edge to the first cycle with rsp_valid=1:
  - 2 cycles for ops 0-5 and 7.
  - max(n,1)+1 cycles for SLL.
- In IDLE and RESP, alu_control=0 and alu_a/alu_b=0, so ALU activity is quiet.
- Width rules: all arithmetic is WIDTH bits and SLL bits shifted past bit WIDTH-1 are discarded. rsp_zero is computed from rsp_data, not from alu_zero.

Test Plan:
- Reset with rst_n=0 mid-SHIFT of SLL shamt=20 -> rsp_valid never asserts; after release req_ready=1, busy=0 and all outputs are 0.
- ADD A=0xFFFFFFFF, B=1, rsp_ready=1 -> rsp_valid 2 cycles after accept, rsp_data=0, rsp_zero=1; busy high for exactly 2 cycles.
- SLT A=0x80000000, B=1 -> rsp_data=1. SLTU with the same operands -> rsp_data=0. EQ A=B=0x1234 -> rsp_data=1.
- SLL A=0x00000003, B=0x00000024 (shamt=4) -> 4 SHIFT cycles, alu_control=0 each cycle, rsp_data=0x30. SLL shamt=0 with A=0xDEADBEEF -> rsp_data=0xDEADBEEF after 2 cycles.
- SLL A=1, shamt=31 -> rsp_data=0x80000000 at latency 32. SLL A=0x80000001, shamt=1 -> rsp_data=0x00000002 (the MSB is dropped).
- OR A=0xF0, B=0x0F with rsp_ready held low for 5 cycles -> rsp_valid stays high and rsp_data=0xFF is stable throughout, and req_ready stays 0 with req_valid held high. After the handshake, the next request is accepted exactly one cycle later.

Source files
------------

// File: rtl/alu_sequencer.sv
`timescale 1ns/1ps
// Sequences requests onto one shared external ALU, composing SLT/SLTU/EQ from SUB
// flags and SLL from repeated self-ADDs. One request in flight at a time.
module alu_sequencer #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       req_op_i,
  input  logic [WIDTH-1:0] req_a_i,
  input  logic [WIDTH-1:0] req_b_i,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  output logic [3:0]       alu_control_o,
  input  logic [WIDTH-1:0] alu_out_i,
  input  logic             alu_zero_i,
  input  logic             alu_neg_i,
  input  logic             alu_carry_i,
  input  logic             alu_overflow_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_data_o,
  output logic             rsp_zero_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {StIdle, StExec, StShift, StResp} state_e;

  typedef enum logic [2:0] {
    OpAdd  = 3'd0,
    OpSub  = 3'd1,
    OpAnd  = 3'd2,
    OpOr   = 3'd3,
    OpSlt  = 3'd4,
    OpSltu = 3'd5,
    OpSll  = 3'd6,
    OpEq   = 3'd7
  } op_e;

  localparam logic [3:0] CtlAdd = 4'd0;
  localparam logic [3:0] CtlSub = 4'd1;

  state_e               state_q;
  op_e                  op_q;
  logic [SHAMT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]     alu_a_q;
  logic [WIDTH-1:0]     alu_b_q;
  logic [3:0]           alu_control_q;
  logic                 rsp_valid_q;
  logic [WIDTH-1:0]     rsp_data_q;
  logic                 rsp_zero_q;
  logic                 busy_q;

  logic [SHAMT_W-1:0]   req_shamt;
  logic [WIDTH-1:0]     exec_result;

  assign req_shamt = req_b_i[SHAMT_W-1:0];

  // Compare results come from the SUB flags; carry is a borrow (A < B unsigned).
  always_comb begin
    exec_result = alu_out_i;
    unique case (op_q)
      OpSlt:   exec_result = {{(WIDTH-1){1'b0}}, alu_neg_i ^ alu_overflow_i};
      OpSltu:  exec_result = {{(WIDTH-1){1'b0}}, alu_carry_i};
      OpEq:    exec_result = {{(WIDTH-1){1'b0}}, alu_zero_i};
      default: exec_result = alu_out_i;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      op_q          <= OpAdd;
      cnt_q         <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_control_q <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_zero_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            op_q   <= op_e'(req_op_i);
            busy_q <= 1'b1;
            if (op_e'(req_op_i) == OpSll) begin
              // alu_a_q doubles as the shift accumulator; shamt=0 adds zero once.
              alu_a_q       <= req_a_i;
              alu_b_q       <= (req_shamt == '0) ? '0 : req_a_i;
              alu_control_q <= CtlAdd;
              cnt_q         <= (req_shamt == '0) ? SHAMT_W'(1) : req_shamt;
              state_q       <= StShift;
            end else begin
              alu_a_q       <= req_a_i;
              alu_b_q       <= req_b_i;
              alu_control_q <= req_op_i[2] ? CtlSub : {1'b0, req_op_i};
              state_q       <= StExec;
            end
          end
        end
        StExec: begin
          rsp_data_q    <= exec_result;
          rsp_zero_q    <= (exec_result == '0);
          rsp_valid_q   <= 1'b1;
          alu_a_q       <= '0;
          alu_b_q       <= '0;
          alu_control_q <= '0;
          state_q       <= StResp;
        end
        StShift: begin
          if (cnt_q == SHAMT_W'(1)) begin
            rsp_data_q    <= alu_out_i;
            rsp_zero_q    <= (alu_out_i == '0);
            rsp_valid_q   <= 1'b1;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_control_q <= '0;
            state_q       <= StResp;
          end else begin
            alu_a_q <= alu_out_i;
            alu_b_q <= alu_out_i;
            cnt_q   <= cnt_q - SHAMT_W'(1);
          end
        end
        StResp: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready_o   = (state_q == StIdle);
  assign alu_a_o       = alu_a_q;
  assign alu_b_o       = alu_b_q;
  assign alu_control_o = alu_control_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_data_o    = rsp_data_q;
  assign rsp_zero_o    = rsp_zero_q;
  assign busy_o        = busy_q;

endmodule
